// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one combinational ALU between two requesters
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_op/req_a/req_b/req_cnt request side
// (packed, requester 1 in upper half); rsp_valid/rsp_ready/rsp_data/rsp_err registered result;
// alu_op/alu_a/alu_b/alu_out external ALU; stat_ops completed-op count, a counter only when
// ALU_SCHED_STATS_EN is defined, otherwise tied to 0.
module alu_sched #(
  parameter int W = 8,
  parameter int CW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [5:0]      req_op,
  input  logic [2*W-1:0]  req_a,
  input  logic [2*W-1:0]  req_b,
  input  logic [2*CW-1:0] req_cnt,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic [2:0]      alu_op,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  input  logic [W-1:0]    alu_out,
  output logic [15:0]     stat_ops
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t st, st_nx;
  logic ptr, g, gsel, err, acc_hs, rsp_hs, shift;
  logic [2:0] op, sel_op;
  logic [W-1:0] acc, b, sel_a, sel_b;
  logic [CW-1:0] k, sel_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else st <= st_nx;
  always_comb begin
    // both valid: grant the requester that did not win last time
    gsel = &req_valid ? ~ptr : req_valid[1];
    sel_op = gsel ? req_op[5:3] : req_op[2:0];
    sel_a = gsel ? req_a[2*W-1:W] : req_a[W-1:0];
    sel_b = gsel ? req_b[2*W-1:W] : req_b[W-1:0];
    sel_cnt = gsel ? req_cnt[2*CW-1:CW] : req_cnt[CW-1:0];
    shift = sel_op == 3'd1 || sel_op == 3'd2;
    acc_hs = st == IDLE && |req_valid;
    rsp_hs = st == RESP && rsp_ready[g];
    st_nx = st;
    if (acc_hs) st_nx = (sel_op == 3'd7 || (shift && sel_cnt == '0)) ? RESP : EXEC;
    else if (st == EXEC && k == CW'(1)) st_nx = RESP;
    else if (rsp_hs) st_nx = IDLE;
    req_ready = acc_hs ? (gsel ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = st == RESP ? (g ? 2'b10 : 2'b01) : 2'b00;
    rsp_data = st == RESP ? acc : '0;
    rsp_err = st == RESP && err;
    alu_op = st == EXEC ? op : 3'd0;
    alu_a = st == EXEC ? acc : '0;
    alu_b = st == EXEC ? b : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= 1'b1;
      g <= 1'b0;
      op <= 3'd0;
      acc <= '0;
      b <= '0;
      k <= '0;
      err <= 1'b0;
    end else if (acc_hs) begin
      ptr <= gsel;
      g <= gsel;
      op <= sel_op;
      b <= sel_b;
      err <= sel_op == 3'd7;
      acc <= sel_op == 3'd7 ? '0 : sel_a;
      k <= shift ? sel_cnt : CW'(1);
    end else if (st == EXEC) begin
      acc <= alu_out;
      k <= k - CW'(1);
    end
`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) stat_ops <= '0;
    else if (rsp_hs && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
`else
  assign stat_ops = '0;
`endif
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched with a behavioural ALU attached
module tb_alu_sched;
  localparam int W = 8;
  localparam int CW = 3;
`ifdef ALU_SCHED_STATS_EN
  localparam logic [15:0] EXP_STATS = 16'd3;
`else
  localparam logic [15:0] EXP_STATS = 16'd0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0] req_op;
  logic [2*W-1:0] req_a, req_b;
  logic [2*CW-1:0] req_cnt;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_out;
  logic rsp_err;
  logic [2:0] alu_op;
  logic [15:0] stat_ops;
  int n_chk = 0;
  int n_fail = 0;

  alu_sched #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .stat_ops(stat_ops)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a << 1;
      3'd2: alu_out = alu_a >> 1;
      3'd3: alu_out = alu_a ^ alu_b;
      3'd4: alu_out = alu_a & alu_b;
      3'd5: alu_out = alu_a - alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] bb,
                       input logic [CW-1:0] cnt);
    req_op[r*3 +: 3] = op;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = bb;
    req_cnt[r*CW +: CW] = cnt;
    req_valid[r] = 1'b1;
  endtask

  initial begin
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_cnt = '0;
    #2;
    check("rst rdy", req_ready, 2'b00);
    check("rst rsp_valid", rsp_valid, 2'b00);
    check("rst data", rsp_data, 8'h00);
    check("rst err", rsp_err, 1'b0);
    check("rst alu", {alu_op, alu_a, alu_b}, 0);
    check("rst stats", stat_ops, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // ADD on requester 0
    drive(0, 3'd0, 8'h12, 8'h34, 3'd0);
    #1 check("add rdy", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    #1 check("add busy", rsp_valid, 2'b00);
    check("add alu_a", alu_a, 8'h12);
    check("add alu_b", alu_b, 8'h34);
    tick;
    check("add valid", rsp_valid, 2'b01);
    check("add data", rsp_data, 8'h46);
    check("add err", rsp_err, 1'b0);
    tick;
    check("add done", rsp_valid, 2'b00);
    // LSH x3 on requester 1
    drive(1, 3'd1, 8'h81, 8'h00, 3'd3);
    #1 check("lsh rdy", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    #1 check("lsh op", alu_op, 3'd1);
    check("lsh a0", alu_a, 8'h81);
    tick;
    check("lsh a1", alu_a, 8'h02);
    check("lsh busy", rsp_valid, 2'b00);
    tick;
    check("lsh a2", alu_a, 8'h04);
    tick;
    check("lsh valid", rsp_valid, 2'b10);
    check("lsh data", rsp_data, 8'h08);
    tick;
    // RSH with zero count completes without touching the ALU
    drive(1, 3'd2, 8'h80, 8'h00, 3'd0);
    #1 check("rsh rdy", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    #1 check("rsh valid", rsp_valid, 2'b10);
    check("rsh data", rsp_data, 8'h80);
    check("rsh alu", alu_op, 3'd0);
    tick;
    // arbitration after reset
    reset = 1'b1;
    #1 reset = 1'b0;
    drive(0, 3'd5, 8'h05, 8'h07, 3'd0);
    drive(1, 3'd3, 8'hF0, 8'h3C, 3'd0);
    #1 check("arb first", req_ready, 2'b01);
    tick;
    check("arb exec rdy", req_ready, 2'b00);
    tick;
    check("sub valid", rsp_valid, 2'b01);
    check("sub data", rsp_data, 8'hFE);
    check("arb resp rdy", req_ready, 2'b00);
    tick;
    check("arb second", req_ready, 2'b10);
    tick;
    tick;
    check("xor valid", rsp_valid, 2'b10);
    check("xor data", rsp_data, 8'hCC);
    tick;
    check("arb third", req_ready, 2'b01);
    req_valid = 2'b00;
    #1;
    // result back-pressure; rsp_ready of the other requester must be ignored
    drive(0, 3'd0, 8'h03, 8'h04, 3'd0);
    rsp_ready = 2'b10;
    #1 check("bp rdy", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    drive(1, 3'd4, 8'hFF, 8'h0F, 3'd0);
    tick;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp valid %0d", i), rsp_valid, 2'b01);
      check($sformatf("bp data %0d", i), rsp_data, 8'h07);
      check($sformatf("bp rdy %0d", i), req_ready, 2'b00);
      tick;
    end
    rsp_ready = 2'b01;
    #1 check("bp hold", rsp_valid, 2'b01);
    tick;
    check("bp next rdy", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    tick;
    check("and valid", rsp_valid, 2'b10);
    check("and data", rsp_data, 8'h0F);
    tick;
    // asynchronous reset in the middle of a long shift
    drive(0, 3'd1, 8'h01, 8'h00, 3'd5);
    tick;
    req_valid = 2'b00;
    tick;
    check("rst mid a", alu_a, 8'h02);
    reset = 1'b1;
    #1 check("rst mid alu", {alu_op, alu_a, alu_b}, 0);
    check("rst mid valid", rsp_valid, 2'b00);
    check("rst mid data", rsp_data, 8'h00);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rst quiet %0d", i), rsp_valid, 2'b00);
      tick;
    end
    drive(0, 3'd0, 8'h01, 8'h01, 3'd0);
    #1 check("post rst rdy", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    #1 check("post rst busy", rsp_valid, 2'b00);
    tick;
    check("post rst valid", rsp_valid, 2'b01);
    check("post rst data", rsp_data, 8'h02);
    tick;
    // illegal opcode
    drive(0, 3'd7, 8'h55, 8'hAA, 3'd0);
    #1 check("ill rdy", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    #1 check("ill valid", rsp_valid, 2'b01);
    check("ill err", rsp_err, 1'b1);
    check("ill data", rsp_data, 8'h00);
    check("ill alu", {alu_op, alu_a, alu_b}, 0);
    tick;
    drive(1, 3'd3, 8'h0F, 8'hF0, 3'd0);
    #1 check("xor2 rdy", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    #1 check("xor2 op", alu_op, 3'd3);
    tick;
    check("xor2 data", rsp_data, 8'hFF);
    check("xor2 err", rsp_err, 1'b0);
    tick;
    check("stats", stat_ops, EXP_STATS);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Scheduler that shares one ALU (3-bit opcodes ADD=0, LSH=1, RSH=2, XOR=3, AND=4, SUB=5, CLR=6) between two requesters, e.g. core issue and test/debug port.
- Provides round-robin arbitration, valid/ready handshakes and a registered result.
- Sequences multi-cycle shifts by issuing LSH/RSH to the ALU once per cycle, `cnt` times.
- Sits between the requesters and the combinational ALU instance.

Parameters:
W, 8, data width of operands and result
CW, 3, shift-count width (max repeat 2^CW-1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept (combinational)
req_op  in  6  packed {op1,op0}, 3 bits each
req_a  in  2W  packed operand A
req_b  in  2W  packed operand B
req_cnt  in  2CW  packed shift repeat count (ignored for non-shift ops)
rsp_valid  out  2  result valid to granted requester
rsp_ready  in  2  per-requester result accept
rsp_data  out  W  result
rsp_err  out  1  illegal opcode flag, valid with rsp_valid
alu_op  out  3  opcode to ALU
alu_a  out  W  ALU operand A
alu_b  out  W  ALU operand B
alu_out  in  W  ALU result, combinational, same cycle
stat_ops  out  16  completed-op count (see Optional Feature)

Behaviour:
- ALU contract, all results mod 2^W:
  - ADD: a+b; SUB: a-b
  - LSH: a<<1; RSH: a>>1 (zero fill)
  - XOR: a^b; AND: a&b; CLR: 0
- Reset values: all outputs 0; FSM=IDLE; last-grant pointer=1, so requester 0 wins first.
- Reset is asynchronous and may hit any state. The in-flight op is discarded with no response, and the first request after deassert is accepted normally.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If only one `req_valid` is set, grant it.
  - If both are set, grant the requester not equal to the pointer.
  - `req_ready[g]`=1 in the same cycle; the handshake occurs when valid&ready.
  - On the handshake, latch op/a/b/cnt, set acc=a, pointer=g, and transition:
    - legal op, not a shift → EXEC with k=1.
    - LSH/RSH with cnt>0 → EXEC with k=cnt.
    - LSH/RSH with cnt=0 → RESP, result=a.
    - op=7 → RESP, result=0, rsp_err=1.
  - `req_ready` is 0 in all other states.
- EXEC:
  - Drive alu_op=op, alu_a=acc, alu_b=b; each cycle acc<=alu_out and k<=k-1.
  - When k reaches 0 → RESP.
  - Outside EXEC, alu_op/alu_a/alu_b=0.
- RESP:
  - `rsp_valid[g]`=1; rsp_data=acc and rsp_err are stable until `rsp_ready[g]`.
  - On the handshake → IDLE. No new accept occurs in the handshake cycle.
  - `rsp_ready` of the non-granted requester is ignored.
- Latency: handshake at cycle T, `rsp_valid` at T+k+1 (T+1 when k=0 or illegal op). Minimum throughput is one op per k+2 cycles.
- Requesters hold op/a/b/cnt stable while valid and not yet accepted. Dropping valid before ready is legal and withdraws the request.

Optional Feature:
- Macro ALU_SCHED_STATS_EN.
- Defined: `stat_ops` is incremented on every rsp handshake (including errors), saturates at 16'hFFFF, and resets to 0.
- Undefined: `stat_ops` is tied to 0 and no counter flops exist.

Test Plan:
- Req0 ADD a=8'h12 b=8'h34, rsp_ready=1 → req_ready[0] in the accept cycle; rsp_valid[0] at T+2, rsp_data=8'h46, rsp_err=0.
- Req1 LSH a=8'h81 cnt=3 → alu_op=1 for 3 cycles with alu_a 81,02,04; rsp_data=8'h08 at T+4; RSH a=8'h80 cnt=0 → 8'h80 at T+1.
- Both valid after reset, req0 SUB 8'h05-8'h07, req1 XOR 8'hF0^8'h3C:
  - req0 granted first → 8'hFE; req1 next → 8'hCC.
  - Both re-requesting then → req0 granted.
- rsp_ready[0] held 0 for 5 cycles with req1 valid → rsp_valid[0] and rsp_data stable; req_ready[1]=0 throughout; req1 accepted the cycle after rsp handshake.
- Reset pulsed during cycle 2 of LSH cnt=5 → all outputs 0 immediately, no response. Next ADD 1+1 gives 8'h02 at T+2.
- Req0 op=3'b111 → rsp_err=1, rsp_data=0 at T+1, ALU never driven. With ALU_SCHED_STATS_EN, after 3 completed ops stat_ops=3; without it, stat_ops=0.
